// File: rtl/ed25519_io_ctrl_if.sv
// Stream and core-side signal bundle for the ed25519 I/O controller.
// The slave modport is the controller; the master modport is its environment.
interface ed25519_io_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PATN_W = 256
);
  logic              i_in_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_out_data;
  logic              o_core_start;
  logic [PATN_W-1:0] o_scalar;
  logic [PATN_W-1:0] o_px;
  logic [PATN_W-1:0] o_py;
  logic              i_core_done;
  logic [PATN_W-1:0] i_qx;
  logic [PATN_W-1:0] i_qy;

  modport slave (
    input  i_in_valid, i_in_data, i_out_ready, i_core_done, i_qx, i_qy,
    output o_in_ready, o_out_valid, o_out_data, o_core_start, o_scalar, o_px, o_py
  );

  modport master (
    output i_in_valid, i_in_data, i_out_ready, i_core_done, i_qx, i_qy,
    input  o_in_ready, o_out_valid, o_out_data, o_core_start, o_scalar, o_px, o_py
  );
endinterface

// File: rtl/ed25519_io_ctrl.sv
// Stream front-end for the ed25519 scalar-multiply core: gathers k/x/y words,
// starts the core, then streams the captured (Qx, Qy) back out MSB word first.
module ed25519_io_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PATN_W = 256
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ed25519_io_ctrl_if.slave  bus
);
  localparam int unsigned IN_WORDS  = 3 * PATN_W / DATA_W;
  localparam int unsigned OUT_WORDS = 2 * PATN_W / DATA_W;
  localparam int unsigned IN_BITS   = 3 * PATN_W;
  localparam int unsigned OUT_BITS  = 2 * PATN_W;
  localparam int unsigned IN_CW     = $clog2(IN_WORDS);
  localparam int unsigned OUT_CW    = $clog2(OUT_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_SEND
  } state_e;

  state_e              r_state,      w_state_nxt;
  logic [IN_BITS-1:0]  r_in_sr,      w_in_sr_nxt;
  logic [OUT_BITS-1:0] r_out_sr,     w_out_sr_nxt;
  logic [IN_CW-1:0]    r_in_cnt,     w_in_cnt_nxt;
  logic [OUT_CW-1:0]   r_out_cnt,    w_out_cnt_nxt;
  logic                r_in_ready,   w_in_ready_nxt;
  logic                r_out_valid,  w_out_valid_nxt;
  logic [DATA_W-1:0]   r_out_data,   w_out_data_nxt;
  logic                r_core_start, w_core_start_nxt;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_in_sr      <= '0;
      r_out_sr     <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_in_sr      <= w_in_sr_nxt;
      r_out_sr     <= w_out_sr_nxt;
      r_in_cnt     <= w_in_cnt_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_core_start <= w_core_start_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt      = r_state;
    w_in_sr_nxt      = r_in_sr;
    w_out_sr_nxt     = r_out_sr;
    w_in_cnt_nxt     = r_in_cnt;
    w_out_cnt_nxt    = r_out_cnt;
    w_in_ready_nxt   = r_in_ready;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_core_start_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_in_ready_nxt = 1'b1;
        w_state_nxt    = S_LOAD;
      end
      S_LOAD: begin
        if (bus.i_in_valid && r_in_ready) begin
          w_in_sr_nxt = {r_in_sr[IN_BITS-DATA_W-1:0], bus.i_in_data};
          if (r_in_cnt == IN_CW'(IN_WORDS - 1)) begin
            w_in_cnt_nxt     = '0;
            w_in_ready_nxt   = 1'b0;
            w_core_start_nxt = 1'b1;
            w_state_nxt      = S_START;
          end else begin
            w_in_cnt_nxt = r_in_cnt + IN_CW'(1);
          end
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_core_done) begin
          w_out_sr_nxt    = {bus.i_qx, bus.i_qy};
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = bus.i_qx[PATN_W-1 -: DATA_W];
          w_state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        // o_out_data already holds the top word; present the one below it next
        if (r_out_valid && bus.i_out_ready) begin
          w_out_sr_nxt   = r_out_sr << DATA_W;
          w_out_data_nxt = r_out_sr[OUT_BITS-DATA_W-1 -: DATA_W];
          if (r_out_cnt == OUT_CW'(OUT_WORDS - 1)) begin
            w_out_cnt_nxt   = '0;
            w_out_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b1;
            w_state_nxt     = S_LOAD;
          end else begin
            w_out_cnt_nxt = r_out_cnt + OUT_CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o_in_ready   = r_in_ready;
  assign bus.o_out_valid  = r_out_valid;
  assign bus.o_out_data   = r_out_data;
  assign bus.o_core_start = r_core_start;
  assign bus.o_scalar     = r_in_sr[IN_BITS-1 -: PATN_W];
  assign bus.o_px         = r_in_sr[2*PATN_W-1 -: PATN_W];
  assign bus.o_py         = r_in_sr[PATN_W-1:0];
endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// Randomized bench for ed25519_io_ctrl: a transaction-level model predicts the
// handshake flags, operands and output words, checked every falling edge.
module tb_ed25519_io_ctrl;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PATN_W = 256;
  localparam logic [255:0] GX = 256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
  localparam logic [255:0] GY = 256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam int P_RST = 0, P_LOAD = 1, P_CORE = 2, P_SEND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ed25519_io_ctrl_if #(.DATA_W(DATA_W), .PATN_W(PATN_W)) bus ();

  ed25519_io_ctrl #(.DATA_W(DATA_W), .PATN_W(PATN_W)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int txn_cnt = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stall 20 cycles on valid rise
  int core_fixed = 0;
  int spur_req = 0;
  logic [63:0] w [12];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model and compare process
  int          phase = P_RST;
  bit          start_cycle = 0;
  logic [63:0] in_q[$];
  logic [63:0] exp_q[$];
  logic [767:0] exp_ops;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("rst_in_ready", 512'(bus.o_in_ready), 512'(0));
      chk("rst_out_valid", 512'(bus.o_out_valid), 512'(0));
      chk("rst_core_start", 512'(bus.o_core_start), 512'(0));
      chk("rst_out_data", 512'(bus.o_out_data), 512'(0));
      chk("rst_operands", 512'({bus.o_scalar, bus.o_px}) | 512'(bus.o_py), 512'(0));
      phase = P_RST;
      start_cycle = 0;
      in_q.delete();
      exp_q.delete();
    end else begin
      chk("in_ready", 512'(bus.o_in_ready), 512'(phase == P_LOAD));
      chk("out_valid", 512'(bus.o_out_valid), 512'(phase == P_SEND));
      chk("core_start", 512'(bus.o_core_start), 512'(phase == P_CORE && start_cycle));
      if (phase == P_CORE || phase == P_SEND) begin
        chk("scalar", 512'(bus.o_scalar), 512'(exp_ops[767:512]));
        chk("px", 512'(bus.o_px), 512'(exp_ops[511:256]));
        chk("py", 512'(bus.o_py), 512'(exp_ops[255:0]));
      end
      if (phase == P_SEND && exp_q.size() > 0)
        chk("out_data", 512'(bus.o_out_data), 512'(exp_q[0]));
      // Advance the model on what the DUT will see at the coming rising edge
      case (phase)
        P_RST: phase = P_LOAD;
        P_LOAD: if (bus.i_in_valid) begin
          in_q.push_back(bus.i_in_data);
          if (in_q.size() == 12) begin
            for (int i = 0; i < 12; i++) exp_ops[767-64*i -: 64] = in_q[i];
            phase = P_CORE;
            start_cycle = 1;
          end
        end
        P_CORE: if (start_cycle) start_cycle = 0;
                else if (bus.i_core_done) begin
                  for (int i = 0; i < 4; i++) exp_q.push_back(bus.i_qx[255-64*i -: 64]);
                  for (int i = 0; i < 4; i++) exp_q.push_back(bus.i_qy[255-64*i -: 64]);
                  phase = P_SEND;
                end
        P_SEND: if (bus.i_out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            phase = P_LOAD;
            in_q.delete();
            txn_cnt++;
          end
        end
        default: phase = P_RST;
      endcase
    end
  end

  // Core model: done three cycles after start, plus on-demand spurious pulses
  initial begin
    int spur_seen = 0;
    bus.i_core_done = 1'b0;
    bus.i_qx = '0;
    bus.i_qy = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        for (int i = 0; i < 8; i++) begin
          bus.i_qx[32*i +: 32] = $urandom;
          bus.i_qy[32*i +: 32] = $urandom;
        end
        bus.i_core_done = 1'b1;
        @(posedge clk); #1;
        bus.i_core_done = 1'b0;
      end else if (bus.o_core_start) begin
        repeat (3) @(posedge clk);
        #1;
        if (core_fixed != 0) begin
          bus.i_qx = {64{4'h1}};
          bus.i_qy = {64{4'h2}};
        end else begin
          for (int i = 0; i < 8; i++) begin
            bus.i_qx[32*i +: 32] = $urandom;
            bus.i_qy[32*i +: 32] = $urandom;
          end
        end
        bus.i_core_done = 1'b1;
        @(posedge clk); #1;
        bus.i_core_done = 1'b0;
      end
    end
  end

  // Downstream ready driver
  initial begin
    int stall = 0;
    logic v_prev = 1'b0;
    bus.i_out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.i_out_ready = 1'b1;
        1: bus.i_out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.o_out_valid && !v_prev) stall = 20;
          if (stall > 0) begin
            bus.i_out_ready = 1'b0;
            stall--;
          end else begin
            bus.i_out_ready = 1'b1;
          end
        end
      endcase
      v_prev = bus.o_out_valid;
    end
  end

  task automatic send_words(input int lo, input int hi, input int prob);
    int idx = lo;
    int guard = 0;
    bit acc;
    while (idx < hi && guard < 2000) begin
      bus.i_in_valid = (int'($urandom_range(0, 99)) < prob);
      bus.i_in_data  = bus.i_in_valid ? w[idx] : {$urandom, $urandom};
      acc = bus.i_in_valid && bus.o_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    bus.i_in_valid = 1'b0;
    chk("words_sent", 512'(idx), 512'(hi));
  endtask

  task automatic wait_txn(input int target);
    int guard = 0;
    while (txn_cnt < target && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("txn_complete", 512'(txn_cnt), 512'(target));
  endtask

  task automatic wait_out_valid();
    int guard = 0;
    while (!bus.o_out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("out_valid_seen", 512'(bus.o_out_valid), 512'(1));
  endtask

  task automatic rand_words();
    for (int i = 0; i < 12; i++) w[i] = {$urandom, $urandom};
  endtask

  initial begin
    logic [255:0] k;
    int base;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic: k = 1 with the ed25519 base point, fixed core result
    core_fixed = 1;
    ready_mode = 0;
    k = 256'h1;
    for (int i = 0; i < 4; i++) begin
      w[i]   = k[255-64*i -: 64];
      w[4+i] = GX[255-64*i -: 64];
      w[8+i] = GY[255-64*i -: 64];
    end
    send_words(0, 12, 100);
    chk("start_after_last_beat", 512'(bus.o_core_start), 512'(1));
    chk("pin_scalar", 512'(bus.o_scalar), 512'(256'h1));
    chk("pin_px", 512'(bus.o_px), 512'(GX));
    chk("pin_py", 512'(bus.o_py), 512'(GY));
    wait_out_valid();
    chk("pin_first_word", 512'(bus.o_out_data), 512'(64'h1111_1111_1111_1111));
    wait_txn(1);
    core_fixed = 0;

    // Random handshake on both sides
    ready_mode = 1;
    base = txn_cnt;
    for (int t = 0; t < 10; t++) begin
      rand_words();
      send_words(0, 12, 50);
      wait_txn(base + t + 1);
    end

    // Output stall of 20 cycles
    ready_mode = 2;
    rand_words();
    send_words(0, 12, 100);
    wait_txn(txn_cnt + 1);

    // Spurious done during load, valid held through wait and stalled send
    rand_words();
    send_words(0, 6, 100);
    spur_req++;
    send_words(6, 12, 100);
    begin
      int guard = 0;
      while (!bus.o_out_valid && guard < 200) begin
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = {$urandom, $urandom};
        @(posedge clk); #1;
        guard++;
      end
      repeat (10) begin
        bus.i_in_data = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      bus.i_in_valid = 1'b0;
    end
    wait_txn(txn_cnt + 1);

    // Reset after five input words, then a full transaction
    ready_mode = 0;
    rand_words();
    send_words(0, 5, 100);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_words();
    send_words(0, 12, 100);
    wait_txn(txn_cnt + 1);

    // Reset after three output beats, then a full transaction
    rand_words();
    send_words(0, 12, 100);
    wait_out_valid();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_words();
    send_words(0, 12, 100);
    wait_txn(txn_cnt + 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ed25519_io_ctrl.md
Name: ed25519_io_ctrl

Overview:
- Stream front-end of the ed25519 top level. Accepts the 12-word, 64-bit input stream: scalar k, then point x, then point y, MSB word first.
- Presents the three 256-bit operands to the scalar-multiply core and fires a start pulse.
- Captures the core's result (Qx, Qy) and streams it back out as 8 words, MSB word first, over a valid/ready port.
- Implements the device side of both halves of the external handshake.

Parameters:
- DATA_W, 64, stream word width.
- PATN_W, 256, operand/coordinate width; must be a multiple of DATA_W.
- IN_WORDS, 3*PATN_W/DATA_W (12), words per input transaction.
- OUT_WORDS, 2*PATN_W/DATA_W (8), words per output transaction.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  input word valid
- o_in_ready  out  1  block can accept an input word
- i_in_data  in  DATA_W  input word
- o_out_valid  out  1  output word valid
- i_out_ready  in  1  downstream accepts output word
- o_out_data  out  DATA_W  output word
- o_core_start  out  1  one-cycle pulse: operands valid, begin computation
- o_scalar  out  PATN_W  k
- o_px  out  PATN_W  input point x
- o_py  out  PATN_W  input point y
- i_core_done  in  1  one-cycle pulse: i_qx/i_qy valid this cycle
- i_qx  in  PATN_W  result x
- i_qy  in  PATN_W  result y

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE, counters=0.
  - o_in_ready=0, o_out_valid=0, o_core_start=0.
  - o_out_data=0, o_scalar/o_px/o_py=0, output shift register=0.
- States: IDLE, LOAD, START, WAIT, SEND.
- IDLE -> LOAD unconditionally on the first edge after reset release. o_in_ready (registered) =1 from that edge.
- LOAD:
  - A beat is accepted at a rising edge with i_in_valid && o_in_ready.
  - The word shifts into the 768-bit input register from the LSB side; word 0 ends in bits [767:704] = k[255:192].
  - in_cnt increments 0..11.
  - On the 12th beat, at that same edge: o_in_ready<=0, state<=START.
  - o_scalar/o_px/o_py are the register's top/middle/low 256 bits, held stable from START until the next LOAD beat.
  - i_in_valid gaps of any length are allowed, with no timeout.
- START:
  - o_core_start=1 for exactly one cycle, then state WAIT.
  - The first beat-to-start latency is 1 cycle after the 12th beat edge.
- WAIT:
  - On the edge where i_core_done=1: capture {i_qx,i_qy} into the 512-bit output shift register.
  - At that edge: o_out_valid<=1, o_out_data<=i_qx[255:192], state<=SEND.
- SEND:
  - Each edge with o_out_valid && i_out_ready: shift left by DATA_W, o_out_data<=next word, out_cnt++.
  - o_out_data and o_out_valid must stay stable while o_out_valid && !i_out_ready.
  - Word order: Qx[255:192], Qx[191:128], Qx[127:64], Qx[63:0], Qy[255:192] … Qy[63:0].
  - On the 8th accepted beat: o_out_valid<=0, o_in_ready<=1, counters cleared, state<=LOAD. No bubble beyond that edge.
- i_core_done outside WAIT is ignored, with no capture.
- i_in_valid outside LOAD is ignored, because o_in_ready=0.
- i_out_ready without o_out_valid has no effect.
- Reset asserted mid-LOAD or mid-SEND discards partial data. After release, the block restarts at IDLE and requires a full 12-word input.
- Back-to-back transactions: a second input stream may begin the cycle after the last output beat.

Test Plan:
- Basic: reset 5 cycles. Drive 12 words with constant valid (k=0x…01, Px/Py = base point). Model core: done 3 cycles after start with Qx=0x1111…, Qy=0x2222…. Required:
  - o_core_start one cycle, 1 cycle after the 12th beat.
  - o_scalar/o_px/o_py match the input bit-exact.
  - 8 output words in MSB-first order.
  - o_in_ready high again the edge after the 8th beat.
- Random handshake: i_in_valid and i_out_ready each 50% random, for 10 transactions. Required:
  - Every word is accepted exactly once.
  - o_out_data never changes while valid && !ready.
  - Outputs match the model.
- Stall: hold i_out_ready=0 for 20 cycles after o_out_valid rises. Required: o_out_data stays = Qx[255:192] and o_out_valid stays 1 throughout. The following beats stream at 1 word per cycle.
- Spurious inputs: i_core_done pulsed during LOAD, and i_in_valid held 1 during WAIT/SEND. Required: no capture and no extra input beats; operands are unchanged.
- Reset mid-transfer: assert i_rst_n=0 after 5 input words. Required:
  - All outputs reach their reset values immediately, without waiting for a clock.
  - A fresh 12-word transaction completes correctly.
- Reset mid-SEND: assert reset after 3 output beats. Required: o_out_valid=0 immediately, and the next transaction's output starts again at Qx[255:192].
